// File: rtl/apb_node_tmo.sv
// APB 1-to-N node: registered decode, unmapped-address error, per-transfer
// timeout watchdog and error bookkeeping (count, last address, irq pulse).

module apb_node_match #(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic          hit
);
    assign hit = (addr >= start_addr) && (addr <= end_addr);
endmodule

module apb_node_tmo #(
    parameter int unsigned NB_MASTER      = 9,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [APB_ADDR_WIDTH-1:0]                     s_paddr,
    input  logic [APB_DATA_WIDTH-1:0]                     s_pwdata,
    input  logic                                          s_pwrite,
    input  logic                                          s_psel,
    input  logic                                          s_penable,
    output logic [APB_DATA_WIDTH-1:0]                     s_prdata,
    output logic                                          s_pready,
    output logic                                          s_pslverr,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      start_addr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      end_addr_i,
    output logic [APB_ADDR_WIDTH-1:0]                     m_paddr,
    output logic [APB_DATA_WIDTH-1:0]                     m_pwdata,
    output logic                                          m_pwrite,
    output logic [NB_MASTER-1:0]                          m_psel,
    output logic                                          m_penable,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      m_prdata,
    input  logic [NB_MASTER-1:0]                          m_pready,
    input  logic [NB_MASTER-1:0]                          m_pslverr,
    input  logic                                          err_clr_i,
    output logic [15:0]                                   err_count_o,
    output logic [APB_ADDR_WIDTH-1:0]                     err_addr_o,
    output logic                                          err_irq_o
);
    localparam int unsigned IDX_W  = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int unsigned WCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [WCNT_W-1:0] WCNT_LAST = TMO_EN ? WCNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, M_SETUP, M_ACCESS, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WCNT_W-1:0]  wcnt;
    logic [NB_MASTER-1:0] hit;
    logic [NB_MASTER-1:0] sel_dec;
    logic [IDX_W-1:0]   hit_idx;
    logic               hit_any;
    logic               setup;
    logic               tmo_hit;
    logic               err_evt;

    for (genvar g = 0; g < NB_MASTER; g++) begin : g_match
        apb_node_match #(.AW(APB_ADDR_WIDTH)) u_match (
            .addr       (s_paddr),
            .start_addr (start_addr_i[g]),
            .end_addr   (end_addr_i[g]),
            .hit        (hit[g])
        );
    end

    // Scanning downward lets the lowest matching port win on overlap.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NB_MASTER - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        sel_dec          = '0;
        sel_dec[hit_idx] = hit_any;
    end

    assign setup   = s_psel && !s_penable;
    assign tmo_hit = TMO_EN && (wcnt == WCNT_LAST);
    assign err_evt = ((state == IDLE) && setup && !hit_any) ||
                     ((state == M_ACCESS) && !m_pready[idx] && tmo_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            wcnt        <= '0;
            s_prdata    <= '0;
            s_pready    <= 1'b0;
            s_pslverr   <= 1'b0;
            m_paddr     <= '0;
            m_pwdata    <= '0;
            m_pwrite    <= 1'b0;
            m_psel      <= '0;
            m_penable   <= 1'b0;
            err_count_o <= '0;
            err_addr_o  <= '0;
            err_irq_o   <= 1'b0;
        end else begin
            err_irq_o <= 1'b0;
            // A clear coinciding with a new error still records that error.
            if (err_evt) begin
                err_count_o <= err_clr_i ? 16'd1 :
                               (err_count_o == 16'hFFFF) ? err_count_o : err_count_o + 16'd1;
                err_addr_o  <= (state == IDLE) ? s_paddr : m_paddr;
                err_irq_o   <= 1'b1;
            end else if (err_clr_i) begin
                err_count_o <= '0;
            end

            case (state)
                IDLE: begin
                    if (setup) begin
                        m_paddr  <= s_paddr;
                        m_pwdata <= s_pwdata;
                        m_pwrite <= s_pwrite;
                        if (hit_any) begin
                            idx    <= hit_idx;
                            wcnt   <= '0;
                            m_psel <= sel_dec;
                            state  <= M_SETUP;
                        end else begin
                            s_prdata  <= ERR_RDATA;
                            s_pslverr <= 1'b1;
                            s_pready  <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                M_SETUP: begin
                    m_penable <= 1'b1;
                    state     <= M_ACCESS;
                end
                M_ACCESS: begin
                    if (m_pready[idx]) begin
                        s_prdata  <= m_prdata[idx];
                        s_pslverr <= m_pslverr[idx];
                        s_pready  <= 1'b1;
                        m_psel    <= '0;
                        m_penable <= 1'b0;
                        state     <= RESP;
                    end else if (tmo_hit) begin
                        s_prdata  <= ERR_RDATA;
                        s_pslverr <= 1'b1;
                        s_pready  <= 1'b1;
                        m_psel    <= '0;
                        m_penable <= 1'b0;
                        state     <= RESP;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                RESP: begin
                    s_pready  <= 1'b0;
                    s_pslverr <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_node_tmo.sv
// Bench for apb_node_tmo: directed vector table, reset/clear sequences and
// randomized transfers checked against a range-scan reference model.

module tb_apb_node_tmo;
    localparam int NM = 4;
    localparam int T  = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [31:0]          s_paddr = '0, s_pwdata = '0;
    logic                 s_pwrite = 1'b0, s_psel = 1'b0, s_penable = 1'b0;
    logic [31:0]          s_prdata;
    logic                 s_pready, s_pslverr;
    logic [NM-1:0][31:0]  start_addr, end_addr;
    logic [31:0]          m_paddr, m_pwdata;
    logic                 m_pwrite, m_penable;
    logic [NM-1:0]        m_psel;
    logic [NM-1:0][31:0]  m_prdata;
    logic [NM-1:0]        m_pready, m_pslverr;
    logic                 err_clr_i = 1'b0;
    logic [15:0]          err_count_o;
    logic [31:0]          err_addr_o;
    logic                 err_irq_o;

    apb_node_tmo #(.NB_MASTER(NM), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32),
                   .TIMEOUT_CYCLES(T), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
        .s_psel(s_psel), .s_penable(s_penable),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .start_addr_i(start_addr), .end_addr_i(end_addr),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
        .m_psel(m_psel), .m_penable(m_penable),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .err_clr_i(err_clr_i), .err_count_o(err_count_o),
        .err_addr_o(err_addr_o), .err_irq_o(err_irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Slave model: answers once it has seen slv_wait enable cycles.
    int          slv_wait = 0;
    int          acc_cnt  = 0;
    logic [3:0]  slv_mask = '0;
    logic [31:0] rd_base  = '0;

    always @(posedge clk_i) acc_cnt <= m_penable ? acc_cnt + 1 : 0;
    assign m_pready  = (acc_cnt >= slv_wait) ? '1 : '0;
    assign m_pslverr = slv_mask;
    always_comb begin
        for (int i = 0; i < NM; i++) m_prdata[i] = rd_base ^ (32'(i) << 24);
    end

    initial begin
        start_addr[0] = 32'h1A10_0000; end_addr[0] = 32'h1A10_0FFF;
        start_addr[1] = 32'h1A10_1000; end_addr[1] = 32'h1A10_1FFF;
        start_addr[2] = 32'h0000_0100; end_addr[2] = 32'h0000_01FF;
        start_addr[3] = 32'h0000_0080; end_addr[3] = 32'h0000_017F;
    end

    int          checks = 0, errors = 0;
    logic [15:0] mdl_cnt  = '0;
    logic [31:0] mdl_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".s_pready"},  32'(s_pready),    32'd0);
        chk({tag, ".s_pslverr"}, 32'(s_pslverr),   32'd0);
        chk({tag, ".s_prdata"},  s_prdata,         32'd0);
        chk({tag, ".m_psel"},    32'(m_psel),      32'd0);
        chk({tag, ".m_penable"}, 32'(m_penable),   32'd0);
        chk({tag, ".m_paddr"},   m_paddr,          32'd0);
        chk({tag, ".m_pwdata"},  m_pwdata,         32'd0);
        chk({tag, ".m_pwrite"},  32'(m_pwrite),    32'd0);
        chk({tag, ".err_count"}, 32'(err_count_o), 32'd0);
        chk({tag, ".err_addr"},  err_addr_o,       32'd0);
        chk({tag, ".err_irq"},   32'(err_irq_o),   32'd0);
    endtask

    // Reference model: first matching range wins; timeout if the slave needs
    // T or more wait states; node errors return the fixed error word.
    task automatic model(input logic [31:0] a, input int wt, input logic [3:0] mask,
                         input logic [31:0] rd, output int lat, output logic [3:0] psel,
                         output logic err, output logic [31:0] rdata, output logic nerr);
        int h = -1;
        for (int i = NM - 1; i >= 0; i--)
            if (a >= start_addr[i] && a <= end_addr[i]) h = i;
        psel = '0;
        if (h < 0) begin
            lat = 1; err = 1'b1; nerr = 1'b1; rdata = 32'hDEAD_BEEF;
        end else begin
            psel[h] = 1'b1;
            if (wt >= T) begin
                lat = T + 2; err = 1'b1; nerr = 1'b1; rdata = 32'hDEAD_BEEF;
            end else begin
                lat = 3 + wt; err = mask[h]; nerr = 1'b0; rdata = rd ^ (32'(h) << 24);
            end
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                        input logic clr, output int lat, output logic [3:0] psel_or,
                        output int en_cyc, output logic [31:0] rdata, output logic err,
                        output int irqs, output int pwd_bad, output logic [3:0] psel_resp);
        @(negedge clk_i);
        s_paddr = a; s_pwdata = wd; s_pwrite = wr; s_psel = 1'b1; s_penable = 1'b0;
        err_clr_i = clr;
        lat = 0; psel_or = '0; en_cyc = 0; irqs = 0; pwd_bad = 0;
        rdata = '0; err = 1'b0; psel_resp = '0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk_i);
            s_penable = 1'b1; err_clr_i = 1'b0;
            psel_or |= m_psel;
            en_cyc  += int'(m_penable);
            irqs    += int'(err_irq_o);
            if (m_pwdata !== wd || m_paddr !== a || m_pwrite !== wr) pwd_bad++;
            if (s_pready) begin
                lat = n; rdata = s_prdata; err = s_pslverr; psel_resp = m_psel;
            end
        end
        s_psel = 1'b0; s_penable = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input logic wr, input logic clr, input int wt, input logic [3:0] mask,
                       input logic [31:0] rd, input int e_lat, input logic [3:0] e_psel,
                       input logic e_err, input logic [31:0] e_rd, input logic e_nerr);
        int lat, en_cyc, irqs, pwd_bad;
        logic [3:0] psel_or, psel_resp;
        logic [31:0] rdata;
        logic err;
        slv_wait = wt; slv_mask = mask; rd_base = rd;
        xfer(a, wd, wr, clr, lat, psel_or, en_cyc, rdata, err, irqs, pwd_bad, psel_resp);
        if (e_nerr) begin
            mdl_cnt  = clr ? 16'd1 : (mdl_cnt == 16'hFFFF ? mdl_cnt : mdl_cnt + 16'd1);
            mdl_addr = a;
        end else if (clr) begin
            mdl_cnt = '0;
        end
        chk({tag, ".latency"},   32'(lat),         32'(e_lat));
        chk({tag, ".psel"},      32'(psel_or),     32'(e_psel));
        chk({tag, ".pslverr"},   32'(err),         32'(e_err));
        chk({tag, ".prdata"},    rdata,            e_rd);
        chk({tag, ".err_count"}, 32'(err_count_o), 32'(mdl_cnt));
        chk({tag, ".err_addr"},  err_addr_o,       mdl_addr);
        chk({tag, ".irq_pulses"}, 32'(irqs),       32'(e_nerr));
        chk({tag, ".penable_cycles"}, 32'(en_cyc), (e_psel != 0) ? 32'(e_lat - 2) : 32'd0);
        chk({tag, ".bcast_stable"}, 32'(pwd_bad),  32'd0);
        chk({tag, ".psel_in_resp"}, 32'(psel_resp), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        int          wt;
        logic [3:0]  mask;
        logic [31:0] rd;
        int          lat;
        logic [3:0]  psel;
        logic        err;
        logic [31:0] rdata;
        logic        nerr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          lat;
        logic [3:0]  psel;
        logic        err, nerr;
        logic [31:0] rdata, a;

        vecs[0]  = '{32'h1A10_1004, 32'h0,         1'b0, 0,  4'b0000, 32'h1334_5678, 3, 4'b0010, 1'b0, 32'h1234_5678, 1'b0};
        vecs[1]  = '{32'h1A10_0010, 32'hCAFE_F00D, 1'b1, 2,  4'b0000, 32'h0,         5, 4'b0001, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{32'h1B00_0000, 32'h0,         1'b0, 0,  4'b0000, 32'h0,         1, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vecs[3]  = '{32'h1A10_0020, 32'h0,         1'b0, 99, 4'b0000, 32'h0,         6, 4'b0001, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vecs[4]  = '{32'h1A10_0020, 32'h0,         1'b0, 3,  4'b0000, 32'h55AA_0000, 6, 4'b0001, 1'b0, 32'h55AA_0000, 1'b0};
        vecs[5]  = '{32'h0000_0100, 32'h0,         1'b0, 0,  4'b0000, 32'h0000_0042, 3, 4'b0100, 1'b0, 32'h0200_0042, 1'b0};
        vecs[6]  = '{32'h0000_0100, 32'h0,         1'b0, 0,  4'b0100, 32'h0,         3, 4'b0100, 1'b1, 32'h0200_0000, 1'b0};
        vecs[7]  = '{32'h0000_0090, 32'h1111_2222, 1'b1, 1,  4'b0000, 32'h0,         4, 4'b1000, 1'b0, 32'h0300_0000, 1'b0};
        vecs[8]  = '{32'h1A10_1FFF, 32'h0,         1'b0, 0,  4'b0000, 32'h0,         3, 4'b0010, 1'b0, 32'h0100_0000, 1'b0};
        vecs[9]  = '{32'h1A10_2000, 32'h0,         1'b0, 0,  4'b0000, 32'h0,         1, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vecs[10] = '{32'h0000_01FF, 32'h0,         1'b0, 0,  4'b1000, 32'h0,         3, 4'b0100, 1'b0, 32'h0200_0000, 1'b0};

        repeat (2) @(posedge clk_i);
        #1;
        chk_reset("init");
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i])
            run($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].write, 1'b0,
                vecs[i].wt, vecs[i].mask, vecs[i].rd, vecs[i].lat, vecs[i].psel,
                vecs[i].err, vecs[i].rdata, vecs[i].nerr);

        // Reset while the downstream transfer sits in ACCESS.
        slv_wait = 99;
        @(negedge clk_i);
        s_paddr = 32'h1A10_0040; s_pwdata = 32'h7777_0000; s_pwrite = 1'b1;
        s_psel = 1'b1; s_penable = 1'b0;
        @(negedge clk_i);
        s_penable = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst.in_access", 32'(m_penable), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk_reset("rst");
        rst_i = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
        mdl_cnt = '0; mdl_addr = '0;
        run("post_rst", vecs[0].addr, 32'h0, 1'b0, 1'b0, 0, 4'b0, vecs[0].rd,
            3, 4'b0010, 1'b0, 32'h1234_5678, 1'b0);

        // Error clear alone and coincident with a new unmapped error.
        run("clr.err1", 32'h2000_0000, 32'h0, 1'b0, 1'b0, 0, 4'b0, 32'h0, 1, 4'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        run("clr.err2", 32'h2000_0004, 32'h0, 1'b0, 1'b0, 0, 4'b0, 32'h0, 1, 4'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        run("clr.coinc", 32'h2000_0008, 32'h0, 1'b0, 1'b1, 0, 4'b0, 32'h0, 1, 4'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        run("clr.only", 32'h1A10_0000, 32'h0, 1'b0, 1'b1, 0, 4'b0, 32'h0, 3, 4'b0001, 1'b0, 32'h0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int          wt;
            logic [3:0]  mask;
            logic [31:0] rd, wd;
            logic        wr, clr;
            case ($urandom_range(0, 4))
                0: a = 32'h1A10_0000 + 32'($urandom_range(0, 32'hFFF));
                1: a = 32'h1A10_1000 + 32'($urandom_range(0, 32'hFFF));
                2: a = 32'h0000_0080 + 32'($urandom_range(0, 32'h17F));
                3: a = $urandom;
                default: a = 32'h1A10_2000 + 32'($urandom_range(0, 15));
            endcase
            wt   = $urandom_range(0, 5);
            mask = 4'($urandom);
            rd   = $urandom;
            wd   = $urandom;
            wr   = 1'($urandom);
            clr  = ($urandom_range(0, 7) == 0);
            model(a, wt, mask, rd, lat, psel, err, rdata, nerr);
            run($sformatf("rnd%0d", r), a, wd, wr, clr, wt, mask, rd, lat, psel, err, rdata, nerr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
